cell_index_pipe: RTL and testbench
==================================

// Module: cell_index_pipe
// PURPOSE
//  Pipelined, parametrised per-particle position update and cell binning for the MD motion-update path.
//  Computes new_pos = (pos + vel) mod L per axis; periodic wrap needs at most one correction.
//  Outputs the integer cell coordinate per axis and the linear cell index x + y*NX + z*NX*NY.
//  Flags particles that migrate between cells and counts them. Valid/ready in and out; 1 particle/cycle.
// PARAMETERS
//  FRAC_W   16                     fraction bits per axis; one cell width = 2^FRAC_W (cutoff-sized cells)
//  NX,NY,NZ 3,3,3                  cells per axis, each >=2; L_axis = N_axis * 2^FRAC_W
//  CW       $clog2(max(NX,NY,NZ))  per-axis cell-coordinate width
//  POS_W    CW+FRAC_W              unsigned position width per axis
//  VEL_W    FRAC_W+1               signed velocity width per axis; |vel| < one cell by construction
//  IDX_W    $clog2(NX*NY*NZ)       linear cell index width
//  CNT_W    16                     migration counter width
// PORTS
//  clk           in   1         clock
//  rst_n         in   1         synchronous active-low reset
//  in_valid      in   1         input particle valid
//  in_ready      out  1         pipeline can accept this cycle
//  in_pos        in   3*POS_W   {z,y,x}, unsigned fixed point
//  in_vel        in   3*VEL_W   {z,y,x}, two's complement
//  in_live       in   1         slot holds a real particle (0 = empty slot)
//  out_valid     out  1         result valid
//  out_ready     in   1         downstream accepts
//  out_pos       out  3*POS_W   wrapped new position {z,y,x}
//  out_cell_xyz  out  3*CW      new cell coordinate {z,y,x}
//  out_cell      out  IDX_W     new linear cell index
//  out_migrated  out  1         live and new index != old index
//  out_live      out  1         in_live passed through
//  mig_clear     in   1         clear migration counter
//  mig_count     out  CNT_W     migrations accepted downstream, saturating
//  err_oor       out  1         sticky: some accepted in_pos axis had value >= N_axis*2^FRAC_W
// BEHAVIOUR
//  Reset (rst_n=0 at clk edge): all stage valids=0, out_valid=0, mig_count=0, err_oor=0.
//   Data registers are don't-care. Reset mid-stream discards all in-flight particles.
//   in_ready is 1 in the first cycle after reset.
//  Pipeline stages:
//   S1 registers sum = pos + sext(vel) at POS_W+2 signed, plus old cell index from pos[FRAC_W+:CW].
//   S2 wraps: sum<0 -> sum + N*2^F; sum >= N*2^F -> sum - N*2^F; else unchanged.
//   S3 registers coords, index (constant multiplies) and migrated.
//  Latency: 3 cycles from accept (in_valid & in_ready) to out_valid, with out_ready held high.
//  Handshake:
//   en3 = !v3 | out_ready; en2 = !v2 | en3; en1 = !v1 | en2; in_ready = en1.
//   Bubbles collapse. A stalled stage holds its data stable. out_* stable while out_valid & !out_ready.
//   in_ready may depend combinationally on out_ready. Never drop or duplicate; order preserved.
//  Dead slot (in_live=0): arithmetic still runs; out_live=0, out_migrated=0, no counter increment.
//  mig_count increments on out_valid & out_ready & out_migrated. It saturates at 2^CNT_W-1.
//   mig_clear has priority over increment: the result is 0 in the same cycle.
//  err_oor sets on accept of an out-of-range pos and clears only by reset. Output uses the same single wrap.
//  Boundaries:
//   pos+vel == L exactly -> 0.
//   pos+vel == -1 LSB -> L-1 LSB.
//   Coord N-1 -> 0 and 0 -> N-1 both count as migrations.
// STRUCTURE
//  Shared package md_pkg holds FRAC_W default, cell-count defaults, and a pos/vel struct typedef.
//  It also holds a function cell_linear(x,y,z) used by this block and the neighbour-cell logic.
//  One sub-module, cell_axis_wrap: the per-axis S1/S2 add+wrap datapath, instantiated 3x.
//  Handshake and counter stay in the top.
// TESTING  (NX=NY=NZ=3, FRAC_W=16; positions in hex)
//  T1 Basic: pos (1.5,0.25,2.0)=(18000,04000,20000), vel (+0.25,0,0)=04000.
//   -> out_pos (1C000,04000,20000), xyz (1,0,2), out_cell 19, migrated 0, after 3 cycles.
//  T2 Positive wrap: x=2E000, vx=+04000.
//   -> x=02000, cell x 0, old index 2 / new 0, migrated=1, mig_count=1.
//  T3 Negative wrap: x=02000, vx=-04000 (1C000 as VEL_W=17).
//   -> x=2E000, cell x 2, migrated=1. Also cover the exact sum = 30000 -> 0 case.
//  T4 Backpressure: out_ready=0 for 6 cycles while 5 particles are offered.
//   -> exactly 3 accepted, in_ready=0, out_* stable.
//   On release, all 5 emerge in order, no duplicates.
//  T5 Reset mid-stream: rst_n=0 for 1 cycle with 3 in flight.
//   -> out_valid=0, mig_count=0 next cycle; none of the 3 ever appear.
//  T6 Dead slot plus counter edges: in_live=0 with a wrapping velocity -> migrated 0, count unchanged.
//   Preload to 2^16-1 -> holds. mig_clear with a migrating output the same cycle -> 0.
//   pos x=30000 -> err_oor=1.

Source files
------------

// File: rtl/md_pkg.sv
// Shared molecular-dynamics definitions: default cell geometry, particle
// state struct and the linear cell-index helper used by the binning logic.
package md_pkg;

    localparam int MD_FRAC_W = 16;
    localparam int MD_NX     = 3;
    localparam int MD_NY     = 3;
    localparam int MD_NZ     = 3;
    localparam int MD_CW     = $clog2(MD_NX > MD_NY ? (MD_NX > MD_NZ ? MD_NX : MD_NZ)
                                                    : (MD_NY > MD_NZ ? MD_NY : MD_NZ));
    localparam int MD_POS_W  = MD_CW + MD_FRAC_W;
    localparam int MD_VEL_W  = MD_FRAC_W + 1;

    typedef struct packed {
        logic [MD_POS_W-1:0] z;
        logic [MD_POS_W-1:0] y;
        logic [MD_POS_W-1:0] x;
    } md_pos_t;

    typedef struct packed {
        logic signed [MD_VEL_W-1:0] z;
        logic signed [MD_VEL_W-1:0] y;
        logic signed [MD_VEL_W-1:0] x;
    } md_vel_t;

    typedef struct packed {
        md_pos_t pos;
        md_vel_t vel;
    } md_particle_t;

    // x-fastest linear numbering; nx/ny are constants at every call site,
    // so the multiplies reduce to shifts and adds.
    function automatic int cell_linear(input int x, input int y, input int z,
                                       input int nx, input int ny);
        return x + y * nx + z * nx * ny;
    endfunction

endpackage

// File: rtl/cell_axis_wrap.sv
// One axis of the motion update: S1 adds the velocity, S2 folds the sum back
// into [0, N*2^FRAC_W) with a single periodic correction.
module cell_axis_wrap #(
    parameter int FRAC_W = 16,
    parameter int N      = 3,
    parameter int POS_W  = 18,
    parameter int VEL_W  = 17
) (
    input  logic             clk,
    input  logic             en1,
    input  logic             en2,
    input  logic [POS_W-1:0] pos,
    input  logic [VEL_W-1:0] vel,
    output logic             oor,
    output logic [POS_W-1:0] wpos
);

    localparam int     SW    = POS_W + 2;
    localparam longint L_VAL = longint'(N) << FRAC_W;
    localparam logic signed [SW-1:0] L_S = SW'(L_VAL);

    logic signed [SW-1:0] sum1;
    logic signed [SW-1:0] wrapped;

    // Two extra bits cover both the negative and the >= L overshoot.
    always_ff @(posedge clk) begin
        if (en1) begin
            sum1 <= $signed({2'b00, pos}) + $signed({{(SW-VEL_W){vel[VEL_W-1]}}, vel});
        end
    end

    always_comb begin
        wrapped = sum1;
        if (sum1 < 0) begin
            wrapped = sum1 + L_S;
        end else if (sum1 >= L_S) begin
            wrapped = sum1 - L_S;
        end
    end

    always_ff @(posedge clk) begin
        if (en2) begin
            wpos <= POS_W'(wrapped);
        end
    end

    assign oor = {1'b0, pos} >= (POS_W+1)'(L_VAL);

endmodule

// File: rtl/cell_index_pipe.sv
// Three-stage particle position update and cell binning with periodic wrap,
// migration flagging and a saturating migration counter.
module cell_index_pipe
    import md_pkg::*;
#(
    parameter int FRAC_W = MD_FRAC_W,
    parameter int NX     = MD_NX,
    parameter int NY     = MD_NY,
    parameter int NZ     = MD_NZ,
    parameter int CW     = $clog2(NX > NY ? (NX > NZ ? NX : NZ) : (NY > NZ ? NY : NZ)),
    parameter int POS_W  = CW + FRAC_W,
    parameter int VEL_W  = FRAC_W + 1,
    parameter int IDX_W  = $clog2(NX * NY * NZ),
    parameter int CNT_W  = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [3*POS_W-1:0] in_pos,
    input  logic [3*VEL_W-1:0] in_vel,
    input  logic               in_live,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [3*POS_W-1:0] out_pos,
    output logic [3*CW-1:0]    out_cell_xyz,
    output logic [IDX_W-1:0]   out_cell,
    output logic               out_migrated,
    output logic               out_live,
    input  logic               mig_clear,
    output logic [CNT_W-1:0]   mig_count,
    output logic               err_oor
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic v1, v2, v3;
    logic en1, en2, en3;
    logic live1, live2;
    logic [IDX_W-1:0] old_idx1, old_idx2;
    logic [IDX_W-1:0] old_idx_d, new_idx_d;
    logic [3*POS_W-1:0] wpos2;
    logic [3*CW-1:0] new_xyz;
    logic [2:0] oor;

    // A transfer happens on any edge where valid and ready are both high;
    // a stage advances when it is empty or the stage after it advances, so
    // bubbles collapse and a stalled stage keeps its contents unchanged.
    assign en3       = !v3 || out_ready;
    assign en2       = !v2 || en3;
    assign en1       = !v1 || en2;
    assign in_ready  = en1;
    assign out_valid = v3;

    for (genvar a = 0; a < 3; a++) begin : g_axis
        cell_axis_wrap #(
            .FRAC_W (FRAC_W),
            .N      (a == 0 ? NX : (a == 1 ? NY : NZ)),
            .POS_W  (POS_W),
            .VEL_W  (VEL_W)
        ) u_axis (
            .clk  (clk),
            .en1  (en1),
            .en2  (en2),
            .pos  (in_pos[a*POS_W +: POS_W]),
            .vel  (in_vel[a*VEL_W +: VEL_W]),
            .oor  (oor[a]),
            .wpos (wpos2[a*POS_W +: POS_W])
        );
        assign new_xyz[a*CW +: CW] = wpos2[a*POS_W + FRAC_W +: CW];
    end

    assign old_idx_d = IDX_W'(cell_linear(32'(in_pos[FRAC_W +: CW]),
                                          32'(in_pos[POS_W + FRAC_W +: CW]),
                                          32'(in_pos[2*POS_W + FRAC_W +: CW]), NX, NY));
    assign new_idx_d = IDX_W'(cell_linear(32'(new_xyz[0 +: CW]),
                                          32'(new_xyz[CW +: CW]),
                                          32'(new_xyz[2*CW +: CW]), NX, NY));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
            v3 <= 1'b0;
        end else begin
            if (en1) v1 <= in_valid;
            if (en2) v2 <= v1;
            if (en3) v3 <= v2;
        end
    end

    always_ff @(posedge clk) begin
        if (en1) begin
            live1    <= in_live;
            old_idx1 <= old_idx_d;
        end
        if (en2) begin
            live2    <= live1;
            old_idx2 <= old_idx1;
        end
        if (en3) begin
            out_pos      <= wpos2;
            out_cell_xyz <= new_xyz;
            out_cell     <= new_idx_d;
            out_migrated <= live2 && (new_idx_d != old_idx2);
            out_live     <= live2;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mig_count <= '0;
        end else if (mig_clear) begin
            mig_count <= '0;
        end else if (out_valid && out_ready && out_migrated && mig_count != CNT_MAX) begin
            mig_count <= mig_count + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_oor <= 1'b0;
        end else if (in_valid && en1 && (|oor)) begin
            err_oor <= 1'b1;
        end
    end

endmodule

// File: tb/tb_cell_index_pipe.sv
// Directed and randomized bench for cell_index_pipe against an arithmetic
// reference model of the periodic position update and cell binning.
module tb_cell_index_pipe;

    localparam int FRAC_W = 16;
    localparam int NX = 3, NY = 3, NZ = 3;
    localparam int CW = 2;
    localparam int POS_W = CW + FRAC_W;
    localparam int VEL_W = FRAC_W + 1;
    localparam int IDX_W = 5;
    localparam int CNT_W = 8;
    localparam int CELL = 1 << FRAC_W;
    localparam int CNT_MAX = (1 << CNT_W) - 1;
    localparam int EW = 3*POS_W + 3*CW + IDX_W + 2;

    logic clk, rst_n;
    logic in_valid, in_ready, in_live;
    logic [3*POS_W-1:0] in_pos;
    logic [3*VEL_W-1:0] in_vel;
    logic out_valid, out_ready, out_migrated, out_live;
    logic [3*POS_W-1:0] out_pos;
    logic [3*CW-1:0] out_cell_xyz;
    logic [IDX_W-1:0] out_cell;
    logic mig_clear, err_oor;
    logic [CNT_W-1:0] mig_count;

    int checks = 0;
    int failures = 0;
    int out_count = 0;
    int exp_mig = 0;
    bit prev_stall = 0;
    logic [EW-1:0] prev_out;
    logic [EW-1:0] exp_q[$];

    cell_index_pipe #(
        .FRAC_W(FRAC_W), .NX(NX), .NY(NY), .NZ(NZ), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_pos(in_pos), .in_vel(in_vel), .in_live(in_live),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pos(out_pos), .out_cell_xyz(out_cell_xyz), .out_cell(out_cell),
        .out_migrated(out_migrated), .out_live(out_live),
        .mig_clear(mig_clear), .mig_count(mig_count), .err_oor(err_oor)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3*POS_W-1:0] pack3p(input int x, input int y, input int z);
        return {POS_W'(z), POS_W'(y), POS_W'(x)};
    endfunction

    function automatic logic [3*VEL_W-1:0] pack3v(input int x, input int y, input int z);
        return {VEL_W'(z), VEL_W'(y), VEL_W'(x)};
    endfunction

    // Reference: integer add, one periodic fold, floor-divide into cells.
    function automatic logic [EW-1:0] model(input logic [3*POS_W-1:0] pos,
                                            input logic [3*VEL_W-1:0] vel, input logic live);
        int len[3];
        int np[3];
        int nc[3];
        int oc[3];
        int nidx, oidx;
        logic mig;
        len[0] = NX * CELL;
        len[1] = NY * CELL;
        len[2] = NZ * CELL;
        for (int a = 0; a < 3; a++) begin
            int p, v, s;
            p = int'(pos[a*POS_W +: POS_W]);
            v = int'($signed(vel[a*VEL_W +: VEL_W]));
            s = p + v;
            if (s < 0) s = s + len[a];
            else if (s >= len[a]) s = s - len[a];
            np[a] = s;
            nc[a] = s / CELL;
            oc[a] = p / CELL;
        end
        nidx = nc[0] + nc[1] * NX + nc[2] * NX * NY;
        oidx = oc[0] + oc[1] * NX + oc[2] * NX * NY;
        mig = live && (nidx != oidx);
        return {POS_W'(np[2]), POS_W'(np[1]), POS_W'(np[0]),
                CW'(nc[2]), CW'(nc[1]), CW'(nc[0]), IDX_W'(nidx), mig, live};
    endfunction

    // scoreboard: pops one expectation per downstream transfer
    always @(negedge clk) begin
        logic [EW-1:0] act;
        logic [EW-1:0] e;
        act = {out_pos, out_cell_xyz, out_cell, out_migrated, out_live};
        check("mig_count", 128'(mig_count), 128'(exp_mig));
        if (prev_stall) begin
            check("stall_valid", 128'(out_valid), 128'(1));
            check("stall_data", 128'(act), 128'(prev_out));
        end
        if (out_valid && out_ready && rst_n) begin
            out_count++;
            if (exp_q.size() == 0) begin
                check("out_unexpected", 128'(exp_q.size()), 128'(1));
            end else begin
                e = exp_q.pop_front();
                check("out_data", 128'(act), 128'(e));
                if (e[1] && exp_mig != CNT_MAX) exp_mig++;
            end
        end
        if (!rst_n || mig_clear) exp_mig = 0;
        prev_stall = out_valid && !out_ready && rst_n;
        prev_out = act;
    end

    // driver tasks
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [3*POS_W-1:0] pos, input logic [3*VEL_W-1:0] vel,
                        input logic live, input int max_cycles, input bit rnd_ready,
                        output bit ok);
        ok = 1'b0;
        in_pos = pos;
        in_vel = vel;
        in_live = live;
        in_valid = 1'b1;
        for (int i = 0; i < max_cycles && !ok; i++) begin
            if (rnd_ready) out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                exp_q.push_back(model(pos, vel, live));
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic put(input string tag, input logic [3*POS_W-1:0] pos,
                       input logic [3*VEL_W-1:0] vel, input logic live);
        bit ok;
        send(pos, vel, live, 20, 1'b0, ok);
        check({tag, "_accept"}, 128'(ok), 128'(1));
    endtask

    task automatic wait_out(input string tag);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (out_valid && out_ready) seen = 1'b1;
        end
        check({tag, "_seen"}, 128'(seen), 128'(1));
    endtask

    task automatic drain(input string tag);
        out_ready = 1'b1;
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) step(1);
        step(2);
        check({tag, "_drained"}, 128'(exp_q.size()), 128'(0));
    endtask

    initial begin
        bit ok;
        int base_cnt;
        rst_n = 1'b0;
        in_valid = 1'b0;
        in_live = 1'b0;
        in_pos = '0;
        in_vel = '0;
        out_ready = 1'b0;
        mig_clear = 1'b0;
        step(2);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_out_valid", 128'(out_valid), 128'(0));
        check("rst_mig_count", 128'(mig_count), 128'(0));
        check("rst_err_oor", 128'(err_oor), 128'(0));
        check("rst_in_ready", 128'(in_ready), 128'(1));
        step(1);
        out_ready = 1'b1;

        // T1 basic move and 3-cycle latency
        put("t1", pack3p('h18000, 'h04000, 'h20000), pack3v('h04000, 0, 0), 1'b1);
        @(negedge clk);
        check("t1_lat1", 128'(out_valid), 128'(0));
        @(negedge clk);
        check("t1_lat2", 128'(out_valid), 128'(0));
        @(negedge clk);
        check("t1_lat3", 128'(out_valid), 128'(1));
        check("t1_pos", 128'(out_pos), 128'(pack3p('h1C000, 'h04000, 'h20000)));
        check("t1_xyz", 128'(out_cell_xyz), 128'({2'd2, 2'd0, 2'd1}));
        check("t1_cell", 128'(out_cell), 128'(19));
        check("t1_mig", 128'(out_migrated), 128'(0));
        step(1);

        // T2 positive wrap
        put("t2", pack3p('h2E000, 0, 0), pack3v('h04000, 0, 0), 1'b1);
        wait_out("t2");
        check("t2_pos_x", 128'(out_pos[POS_W-1:0]), 128'('h02000));
        check("t2_cell_x", 128'(out_cell_xyz[CW-1:0]), 128'(0));
        check("t2_cell", 128'(out_cell), 128'(0));
        check("t2_mig", 128'(out_migrated), 128'(1));
        step(2);
        check("t2_mig_count", 128'(mig_count), 128'(1));

        // T3 negative wrap, exact L and -1 LSB
        put("t3n", pack3p('h02000, 0, 0), pack3v(-'h04000, 0, 0), 1'b1);
        wait_out("t3n");
        check("t3n_pos_x", 128'(out_pos[POS_W-1:0]), 128'('h2E000));
        check("t3n_cell_x", 128'(out_cell_xyz[CW-1:0]), 128'(2));
        check("t3n_mig", 128'(out_migrated), 128'(1));
        step(1);
        put("t3l", pack3p('h2F000, 0, 0), pack3v('h01000, 0, 0), 1'b1);
        wait_out("t3l");
        check("t3l_pos_x", 128'(out_pos[POS_W-1:0]), 128'(0));
        check("t3l_mig", 128'(out_migrated), 128'(1));
        step(1);
        put("t3m", pack3p(0, 'h10000, 0), pack3v(-1, 0, 0), 1'b1);
        wait_out("t3m");
        check("t3m_pos_x", 128'(out_pos[POS_W-1:0]), 128'('h2FFFF));
        check("t3m_cell", 128'(out_cell), 128'(5));
        step(1);
        drain("t3");

        // T4 backpressure: 6 stalled cycles, 5 offered
        base_cnt = out_count;
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            send(pack3p('h04000 + k * 'h8000, 'h10000, 'h21000), pack3v('h100, 0, 0), 1'b1, 1, 1'b0, ok);
            check("t4_accept", 128'(ok), 128'(1));
        end
        send(pack3p('h1C000, 'h10000, 'h21000), pack3v('h100, 0, 0), 1'b1, 3, 1'b0, ok);
        check("t4_refused", 128'(ok), 128'(0));
        check("t4_in_ready", 128'(in_ready), 128'(0));
        check("t4_hold_valid", 128'(out_valid), 128'(1));
        check("t4_hold_pos", 128'(out_pos), 128'(pack3p('h04100, 'h10000, 'h21000)));
        out_ready = 1'b1;
        for (int k = 3; k < 5; k++) begin
            put("t4_rel", pack3p('h04000 + k * 'h8000, 'h10000, 'h21000), pack3v('h100, 0, 0), 1'b1);
        end
        drain("t4");
        check("t4_out_count", 128'(out_count - base_cnt), 128'(5));

        // T5 reset with three in flight
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            send(pack3p('h2E000, 'h01000 * k, 0), pack3v('h04000, 0, 0), 1'b1, 1, 1'b0, ok);
            check("t5_accept", 128'(ok), 128'(1));
        end
        base_cnt = out_count;
        rst_n = 1'b0;
        exp_q.delete();
        step(1);
        rst_n = 1'b1;
        @(negedge clk);
        check("t5_out_valid", 128'(out_valid), 128'(0));
        check("t5_mig_count", 128'(mig_count), 128'(0));
        check("t5_in_ready", 128'(in_ready), 128'(1));
        step(1);
        out_ready = 1'b1;
        step(10);
        check("t5_no_ghosts", 128'(out_count - base_cnt), 128'(0));

        // randomized traffic with random downstream stalls
        for (int n = 0; n < 300; n++) begin
            int px, py, pz, vx, vy, vz;
            px = int'($urandom_range(0, NX * CELL - 1));
            py = int'($urandom_range(0, NY * CELL - 1));
            pz = int'($urandom_range(0, NZ * CELL - 1));
            vx = int'($urandom_range(0, 2 * CELL - 2)) - (CELL - 1);
            vy = int'($urandom_range(0, 2 * CELL - 2)) - (CELL - 1);
            vz = int'($urandom_range(0, 2 * CELL - 2)) - (CELL - 1);
            send(pack3p(px, py, pz), pack3v(vx, vy, vz), ($urandom_range(0, 4) != 0), 50, 1'b1, ok);
            check("rnd_accept", 128'(ok), 128'(1));
        end
        drain("rnd");

        // T6 dead slot, saturation, clear priority, out-of-range
        put("t6d", pack3p('h2E000, 0, 0), pack3v('h04000, 0, 0), 1'b0);
        wait_out("t6d");
        check("t6d_mig", 128'(out_migrated), 128'(0));
        check("t6d_live", 128'(out_live), 128'(0));
        step(1);
        for (int k = 0; k < CNT_MAX + 5; k++) begin
            put("t6s", pack3p('h2E000, 0, 0), pack3v('h04000, 0, 0), 1'b1);
        end
        drain("t6s");
        check("t6_saturated", 128'(mig_count), 128'(CNT_MAX));
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            send(pack3p('h2E000, 0, 0), pack3v('h04000, 0, 0), 1'b1, 1, 1'b0, ok);
            check("t6c_accept", 128'(ok), 128'(1));
        end
        out_ready = 1'b1;
        mig_clear = 1'b1;
        step(1);
        mig_clear = 1'b0;
        @(negedge clk);
        check("t6_clear_wins", 128'(mig_count), 128'(0));
        drain("t6c");
        check("t6_after_clear", 128'(mig_count), 128'(2));
        check("t6_oor_before", 128'(err_oor), 128'(0));
        put("t6o", pack3p('h30000, 0, 0), pack3v(0, 0, 0), 1'b1);
        check("t6_oor_set", 128'(err_oor), 128'(1));
        drain("t6o");
        check("t6_oor_sticky", 128'(err_oor), 128'(1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
